vector_element_sequencer: RTL and testbench
===========================================

# vector_element_sequencer

Sequences a vector instruction over the vector register file one element per cycle. On a start handshake it samples the current vector configuration (vl, vstart, vill, vsew, vlmul) and the mask register, then checks legality. It then streams element descriptors (element index, physical register, bit offset, mask-active flag) to the vector datapath under valid/ready backpressure. Progress is written back to vstart so a flushed instruction restarts precisely.

## Interface
- VLEN, 128: bits per vector register; power of two, ≥ 32.
- SYS_clk  in  1  clock; all state updates on rising edge.
- SYS_reset  in  1  asynchronous, active-low reset.
- start_valid  in  1  instruction issue request.
- start_ready  out  1  = (state==IDLE) && !flush.
- start_vd, start_vs1, start_vs2  in  5 each  base register numbers.
- start_masked  in  1  1 = element gated by mask bit (vm=0).
- vl, vstart  in  32 each  sampled on accept.
- vill  in  1; vsew, vlmul  in  3 each  sampled on accept.
- mask_registers  in  VLEN  sampled on accept; bit i masks element i.
- flush  in  1  synchronous abort.
- elem_valid  out  1; elem_ready  in  1  element handshake.
- elem_idx  out  32  element index.
- elem_vd, elem_vs1, elem_vs2  out  5 each  base + register-group offset.
- elem_bit_offset  out  log2(VLEN)  LSB position of the element within its register.
- elem_active  out  1  = !masked_q || mask_q[elem_idx].
- elem_last  out  1  element is the final one.
- vstart_we  out  1; new_vstart  out  32  vstart write-back.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse on normal completion.
- illegal  out  1  one-cycle pulse on rejected instruction.

## Operation
- States: IDLE, RUN, DONE, ILL. Reset forces IDLE. All registered outputs and captured fields reset to 0. start_ready=1 while in reset.
- SEW: vsew 000/001/010 gives 8/16/32. Any other value is illegal.
- LMUL: vlmul 000..011 gives 1, 2, 4, 8. Values 101/110/111 give 1/8, 1/4, 1/2. Value 100 is illegal.
- VLMAX = (VLEN/SEW)·LMUL, computed with shifts. Fractional VLMAX < 1 is illegal.
- vl_eff = min(vl, VLMAX).
- Illegal also when vill=1, or when LMUL>1 and any of vd/vs1/vs2 is not a multiple of LMUL.
- On accept in IDLE, the next state is:
  - ILL if the instruction is illegal;
  - else DONE if vstart ≥ vl_eff;
  - else RUN with elem_idx=vstart.
- RUN outputs:
  - elem_valid=1 and epr=VLEN/SEW.
  - elem_vX = base + elem_idx/epr.
  - elem_bit_offset = (elem_idx mod epr)·SEW.
  - elem_last = (elem_idx == vl_eff−1).
- Handshake (elem_valid && elem_ready):
  - vstart_we=1 the same cycle (combinational).
  - new_vstart = elem_last ? 0 : elem_idx+1.
  - If not last: elem_idx increments.
  - If last: next state is DONE.
- No handshake: all elem_* outputs hold stable and vstart_we=0.
- DONE: done=1 for one cycle, then IDLE.
  - When DONE is entered via the empty case, vstart_we=1 and new_vstart=0 in that cycle.
- ILL: illegal=1 for one cycle, then IDLE. No elements are issued and vstart is not written.
- flush has priority over every other event in every state.
  - It returns the block to IDLE next cycle with no done/illegal pulse.
  - A handshake in the flush cycle still writes vstart.
  - The written vstart remains the restart point.

## Timing
- Accept at edge N gives the first elem_valid in cycle N+1.
- With elem_ready held high, one element per cycle.
- done asserts the cycle after the last handshake.
- Total for k elements with no stalls: k+1 cycles after accept.
- The empty and illegal paths produce done/illegal in cycle N+1.
- Back-to-back: a new start is accepted in the cycle after DONE/ILL, i.e. when IDLE is re-entered.
- Asynchronous reset mid-RUN: elem_valid, vstart_we, done and illegal drop immediately. There is no write-back.

## Test plan
- Basic run (VLEN=128): vsew=010, vlmul=000, vl=4, vstart=0, vd=2, unmasked, elem_ready=1.
  - Expect idx 0..3 with bit offsets 0, 32, 64, 96 and elem_vd=2.
  - elem_last on idx 3; new_vstart 1, 2, 3, 0.
  - done in cycle N+5.
- Clamp and grouping: vsew=000, vlmul=001, vl=40, vd=4.
  - vl_eff=32; idx 16 gives elem_vd=5 with offset 0.
  - Last is idx 31 with offset 120.
- Mask: start_masked=1, mask=0x5, vl=4, sew 32.
  - Expect elem_active 1, 0, 1, 0; all four elements are still issued.
- Backpressure: drop elem_ready for 3 cycles at idx 1.
  - Outputs stay stable and vstart_we=0.
  - Resume at idx 1; done is delayed by exactly 3 cycles.
- Illegal/empty:
  - vlmul=100 gives an illegal pulse at N+1 with no elem_valid.
  - vlmul=001 with vd=3 gives the same result.
  - vill=1 gives the same result.
  - vstart=5, vl=3 gives done at N+1 with new_vstart=0.
- Flush/reset:
  - Flush during the handshake of idx 2 writes new_vstart=3, returns to IDLE, no done.
  - Restart with vstart=3 issues idx 3 first.
  - Async reset mid-RUN zeroes all outputs immediately.

Source files
------------

// File: rtl/vector_element_sequencer_if.sv
// rtl/vector_element_sequencer_if.sv - issue, element and vstart write-back signals of the element sequencer
interface vector_element_sequencer_if #(
  parameter int VLEN = 128
);
  localparam int LW = $clog2(VLEN);

  logic            start_valid;
  logic            start_ready;
  logic [4:0]      start_vd;
  logic [4:0]      start_vs1;
  logic [4:0]      start_vs2;
  logic            start_masked;
  logic [31:0]     vl;
  logic [31:0]     vstart;
  logic            vill;
  logic [2:0]      vsew;
  logic [2:0]      vlmul;
  logic [VLEN-1:0] mask_registers;
  logic            flush;
  logic            elem_valid;
  logic            elem_ready;
  logic [31:0]     elem_idx;
  logic [4:0]      elem_vd;
  logic [4:0]      elem_vs1;
  logic [4:0]      elem_vs2;
  logic [LW-1:0]   elem_bit_offset;
  logic            elem_active;
  logic            elem_last;
  logic            vstart_we;
  logic [31:0]     new_vstart;
  logic            busy;
  logic            done;
  logic            illegal;

  modport slave (
    input  start_valid, start_vd, start_vs1, start_vs2, start_masked,
    input  vl, vstart, vill, vsew, vlmul, mask_registers, flush, elem_ready,
    output start_ready, elem_valid, elem_idx, elem_vd, elem_vs1, elem_vs2,
    output elem_bit_offset, elem_active, elem_last, vstart_we, new_vstart,
    output busy, done, illegal
  );

  modport master (
    output start_valid, start_vd, start_vs1, start_vs2, start_masked,
    output vl, vstart, vill, vsew, vlmul, mask_registers, flush, elem_ready,
    input  start_ready, elem_valid, elem_idx, elem_vd, elem_vs1, elem_vs2,
    input  elem_bit_offset, elem_active, elem_last, vstart_we, new_vstart,
    input  busy, done, illegal
  );
endinterface

// File: rtl/vector_element_sequencer.sv
// rtl/vector_element_sequencer.sv - issues one vector element descriptor per cycle with vstart write-back
module vector_element_sequencer #(
  parameter int VLEN = 128
) (
  input  logic                       SYS_clk,
  input  logic                       SYS_reset,
  vector_element_sequencer_if.slave  bus
);
  localparam int LW = $clog2(VLEN);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ILL} state_t;

  state_t          r_state;
  logic [31:0]     r_idx;
  logic [31:0]     r_vl_eff;
  logic [2:0]      r_sew_sh;
  logic [4:0]      r_vd;
  logic [4:0]      r_vs1;
  logic [4:0]      r_vs2;
  logic            r_masked;
  logic [VLEN-1:0] r_mask;
  logic            r_empty;

  logic [2:0]  w_sew_sh;
  logic        w_sew_ok;
  logic        w_lmul_ok;
  logic [31:0] w_base;
  logic [31:0] w_vlmax;
  logic [4:0]  w_align;
  logic        w_misaligned;
  logic        w_illegal;
  logic [31:0] w_vl_eff;
  logic        w_empty;

  always_comb begin
    w_sew_sh  = 3'd3;
    w_sew_ok  = 1'b1;
    w_lmul_ok = 1'b1;
    w_align   = 5'd0;
    case (bus.vsew)
      3'b000:  w_sew_sh = 3'd3;
      3'b001:  w_sew_sh = 3'd4;
      3'b010:  w_sew_sh = 3'd5;
      default: w_sew_ok = 1'b0;
    endcase
    w_base = 32'(VLEN) >> w_sew_sh;
    case (bus.vlmul)
      3'b000, 3'b001, 3'b010, 3'b011: begin
        w_vlmax = w_base << bus.vlmul[1:0];
        w_align = (5'd1 << bus.vlmul[1:0]) - 5'd1;
      end
      3'b101:  w_vlmax = w_base >> 3;
      3'b110:  w_vlmax = w_base >> 2;
      3'b111:  w_vlmax = w_base >> 1;
      default: begin
        w_vlmax   = 32'd0;
        w_lmul_ok = 1'b0;
      end
    endcase
    // Register groups must start on an LMUL-aligned register number.
    w_misaligned = |((bus.start_vd | bus.start_vs1 | bus.start_vs2) & w_align);
    w_illegal    = bus.vill || !w_sew_ok || !w_lmul_ok || (w_vlmax == 32'd0) || w_misaligned;
    w_vl_eff     = (bus.vl < w_vlmax) ? bus.vl : w_vlmax;
    w_empty      = (bus.vstart >= w_vl_eff);
  end

  logic        w_run;
  logic        w_hs;
  logic        w_last;
  logic [39:0] w_scaled;
  logic [4:0]  w_group;

  // idx*SEW splits into the register-group offset (high bits) and bit offset (low bits).
  assign w_run    = (r_state == S_RUN);
  assign w_hs     = w_run && bus.elem_ready;
  assign w_last   = (r_idx == r_vl_eff - 32'd1);
  assign w_scaled = {8'd0, r_idx} << r_sew_sh;
  assign w_group  = 5'(w_scaled >> LW);

  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_vl_eff <= '0;
      r_sew_sh <= '0;
      r_vd     <= '0;
      r_vs1    <= '0;
      r_vs2    <= '0;
      r_masked <= 1'b0;
      r_mask   <= '0;
      r_empty  <= 1'b0;
    end else if (bus.flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start_valid) begin
            r_idx    <= bus.vstart;
            r_vl_eff <= w_vl_eff;
            r_sew_sh <= w_sew_sh;
            r_vd     <= bus.start_vd;
            r_vs1    <= bus.start_vs1;
            r_vs2    <= bus.start_vs2;
            r_masked <= bus.start_masked;
            r_mask   <= bus.mask_registers;
            r_empty  <= w_empty;
            if (w_illegal)    r_state <= S_ILL;
            else if (w_empty) r_state <= S_DONE;
            else              r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (bus.elem_ready) begin
            if (w_last) begin
              r_state <= S_DONE;
              r_empty <= 1'b0;
            end else begin
              r_idx <= r_idx + 32'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.start_ready     = (r_state == S_IDLE) && !bus.flush;
  assign bus.busy            = (r_state != S_IDLE);
  assign bus.done            = (r_state == S_DONE) && !bus.flush;
  assign bus.illegal         = (r_state == S_ILL) && !bus.flush;
  assign bus.elem_valid      = w_run;
  assign bus.elem_idx        = w_run ? r_idx : 32'd0;
  assign bus.elem_vd         = w_run ? r_vd + w_group : 5'd0;
  assign bus.elem_vs1        = w_run ? r_vs1 + w_group : 5'd0;
  assign bus.elem_vs2        = w_run ? r_vs2 + w_group : 5'd0;
  assign bus.elem_bit_offset = w_run ? w_scaled[LW-1:0] : '0;
  assign bus.elem_active     = w_run && (!r_masked || r_mask[r_idx[LW-1:0]]);
  assign bus.elem_last       = w_run && w_last;
  // The empty path still clears vstart so the architectural state is consistent.
  assign bus.vstart_we       = w_hs || ((r_state == S_DONE) && r_empty);
  assign bus.new_vstart      = (w_run && !w_last) ? r_idx + 32'd1 : 32'd0;
endmodule

// File: tb/tb_vector_element_sequencer.sv
// tb/tb_vector_element_sequencer.sv - directed self-checking bench for vector_element_sequencer
module tb_vector_element_sequencer;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  vector_element_sequencer_if #(.VLEN(128)) vif ();

  vector_element_sequencer #(.VLEN(128)) dut (
    .SYS_clk   (clk),
    .SYS_reset (rst_n),
    .bus       (vif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] vd, input logic [4:0] vs1, input logic [4:0] vs2,
                       input logic masked, input logic [31:0] vl, input logic [31:0] vst,
                       input logic vill, input logic [2:0] sew, input logic [2:0] lmul,
                       input logic [127:0] mask);
    vif.start_vd       = vd;
    vif.start_vs1      = vs1;
    vif.start_vs2      = vs2;
    vif.start_masked   = masked;
    vif.vl             = vl;
    vif.vstart         = vst;
    vif.vill           = vill;
    vif.vsew           = sew;
    vif.vlmul          = lmul;
    vif.mask_registers = mask;
    vif.start_valid    = 1'b1;
    step();
    vif.start_valid    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (vif.start_ready !== 1'b1) begin failures++; $display("FAIL reset_start_ready got=%0d exp=1", vif.start_ready); end
    checks++; if (vif.elem_valid !== 1'b0) begin failures++; $display("FAIL reset_elem_valid got=%0d exp=0", vif.elem_valid); end
    checks++; if (vif.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0d exp=0", vif.busy); end
    checks++; if (vif.done !== 1'b0 || vif.illegal !== 1'b0) begin failures++; $display("FAIL reset_pulses got=%0d%0d exp=00", vif.done, vif.illegal); end
    checks++; if (vif.vstart_we !== 1'b0 || vif.new_vstart !== 32'd0) begin failures++; $display("FAIL reset_vstart got=%0d/%0d exp=0/0", vif.vstart_we, vif.new_vstart); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    vif.elem_ready = 1'b1;
    issue(5'd2, 5'd0, 5'd0, 1'b0, 32'd4, 32'd0, 1'b0, 3'b010, 3'b000, 128'd0);
    for (int i = 0; i < 4; i++) begin
      checks++; if (vif.elem_valid !== 1'b1 || vif.elem_idx !== 32'(i)) begin failures++; $display("FAIL basic_idx got=%0d/%0d exp=1/%0d", vif.elem_valid, vif.elem_idx, i); end
      checks++; if (vif.elem_bit_offset !== 7'(i * 32) || vif.elem_vd !== 5'd2) begin failures++; $display("FAIL basic_offset_vd got=%0d/%0d exp=%0d/2", vif.elem_bit_offset, vif.elem_vd, i * 32); end
      checks++; if (vif.elem_last !== (i == 3)) begin failures++; $display("FAIL basic_last i=%0d got=%0d", i, vif.elem_last); end
      checks++; if (vif.vstart_we !== 1'b1 || vif.new_vstart !== ((i == 3) ? 32'd0 : 32'(i + 1))) begin failures++; $display("FAIL basic_new_vstart i=%0d got=%0d/%0d", i, vif.vstart_we, vif.new_vstart); end
      step();
    end
    checks++; if (vif.done !== 1'b1 || vif.elem_valid !== 1'b0) begin failures++; $display("FAIL basic_done got=%0d/%0d exp=1/0", vif.done, vif.elem_valid); end
    step();
    checks++; if (vif.done !== 1'b0 || vif.busy !== 1'b0) begin failures++; $display("FAIL basic_idle got=%0d/%0d exp=0/0", vif.done, vif.busy); end
  endtask

  task automatic test_clamp_group();
    int n;
    n = 0;
    issue(5'd4, 5'd6, 5'd8, 1'b0, 32'd40, 32'd0, 1'b0, 3'b000, 3'b001, 128'd0);
    while (vif.elem_valid === 1'b1 && n < 40) begin
      checks++; if (vif.elem_idx !== 32'(n) || vif.elem_vd !== 5'(4 + n / 16) || vif.elem_bit_offset !== 7'((n % 16) * 8)) begin failures++; $display("FAIL clamp_elem n=%0d got idx=%0d vd=%0d off=%0d", n, vif.elem_idx, vif.elem_vd, vif.elem_bit_offset); end
      if (n == 16) begin
        checks++; if (vif.elem_vs1 !== 5'd7 || vif.elem_vs2 !== 5'd9) begin failures++; $display("FAIL clamp_vs got=%0d/%0d exp=7/9", vif.elem_vs1, vif.elem_vs2); end
      end
      checks++; if (vif.elem_last !== (n == 31)) begin failures++; $display("FAIL clamp_last n=%0d got=%0d", n, vif.elem_last); end
      n++;
      step();
    end
    checks++; if (n !== 32) begin failures++; $display("FAIL clamp_count got=%0d exp=32", n); end
    checks++; if (vif.done !== 1'b1) begin failures++; $display("FAIL clamp_done got=%0d exp=1", vif.done); end
    step();
  endtask

  task automatic test_mask();
    logic [3:0] exp_act;
    exp_act = 4'b0101;
    issue(5'd0, 5'd0, 5'd0, 1'b1, 32'd4, 32'd0, 1'b0, 3'b010, 3'b000, 128'h5);
    for (int i = 0; i < 4; i++) begin
      checks++; if (vif.elem_valid !== 1'b1 || vif.elem_active !== exp_act[i]) begin failures++; $display("FAIL mask_active i=%0d got=%0d/%0d exp=1/%0d", i, vif.elem_valid, vif.elem_active, exp_act[i]); end
      step();
    end
    checks++; if (vif.done !== 1'b1) begin failures++; $display("FAIL mask_done got=%0d exp=1", vif.done); end
    step();
  endtask

  task automatic test_backpressure();
    issue(5'd2, 5'd0, 5'd0, 1'b0, 32'd4, 32'd0, 1'b0, 3'b010, 3'b000, 128'd0);
    checks++; if (vif.elem_idx !== 32'd0 || vif.vstart_we !== 1'b1) begin failures++; $display("FAIL bp_first got=%0d/%0d exp=0/1", vif.elem_idx, vif.vstart_we); end
    step();
    vif.elem_ready = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (vif.elem_valid !== 1'b1 || vif.elem_idx !== 32'd1 || vif.elem_bit_offset !== 7'd32 || vif.elem_last !== 1'b0) begin failures++; $display("FAIL bp_hold k=%0d got v=%0d idx=%0d off=%0d", k, vif.elem_valid, vif.elem_idx, vif.elem_bit_offset); end
      checks++; if (vif.vstart_we !== 1'b0) begin failures++; $display("FAIL bp_no_we k=%0d got=%0d exp=0", k, vif.vstart_we); end
      step();
    end
    vif.elem_ready = 1'b1;
    #1;
    checks++; if (vif.elem_idx !== 32'd1 || vif.vstart_we !== 1'b1 || vif.new_vstart !== 32'd2) begin failures++; $display("FAIL bp_resume got idx=%0d we=%0d nv=%0d exp=1/1/2", vif.elem_idx, vif.vstart_we, vif.new_vstart); end
    step();
    step();
    checks++; if (vif.done !== 1'b0 || vif.elem_idx !== 32'd3) begin failures++; $display("FAIL bp_n7 got done=%0d idx=%0d exp=0/3", vif.done, vif.elem_idx); end
    step();
    checks++; if (vif.done !== 1'b1) begin failures++; $display("FAIL bp_done_n8 got=%0d exp=1", vif.done); end
    step();
  endtask

  task automatic test_illegal();
    logic [2:0] sew_t  [5];
    logic [2:0] lmul_t [5];
    logic [4:0] vd_t   [5];
    logic       vill_t [5];
    sew_t  = '{3'b010, 3'b010, 3'b010, 3'b011, 3'b010};
    lmul_t = '{3'b100, 3'b001, 3'b000, 3'b000, 3'b101};
    vd_t   = '{5'd0,   5'd3,   5'd0,   5'd0,   5'd0};
    vill_t = '{1'b0,   1'b0,   1'b1,   1'b0,   1'b0};
    for (int c = 0; c < 5; c++) begin
      issue(vd_t[c], 5'd0, 5'd0, 1'b0, 32'd4, 32'd0, vill_t[c], sew_t[c], lmul_t[c], 128'd0);
      checks++; if (vif.illegal !== 1'b1 || vif.elem_valid !== 1'b0 || vif.done !== 1'b0) begin failures++; $display("FAIL illegal_pulse c=%0d got ill=%0d v=%0d d=%0d exp=1/0/0", c, vif.illegal, vif.elem_valid, vif.done); end
      checks++; if (vif.vstart_we !== 1'b0) begin failures++; $display("FAIL illegal_no_we c=%0d got=%0d exp=0", c, vif.vstart_we); end
      step();
      checks++; if (vif.illegal !== 1'b0 || vif.busy !== 1'b0) begin failures++; $display("FAIL illegal_end c=%0d got=%0d/%0d exp=0/0", c, vif.illegal, vif.busy); end
    end
  endtask

  task automatic test_empty();
    logic [31:0] vl_t [2];
    logic [31:0] vs_t [2];
    vl_t = '{32'd3, 32'd0};
    vs_t = '{32'd5, 32'd0};
    for (int c = 0; c < 2; c++) begin
      issue(5'd0, 5'd0, 5'd0, 1'b0, vl_t[c], vs_t[c], 1'b0, 3'b010, 3'b000, 128'd0);
      checks++; if (vif.done !== 1'b1 || vif.elem_valid !== 1'b0) begin failures++; $display("FAIL empty_done c=%0d got=%0d/%0d exp=1/0", c, vif.done, vif.elem_valid); end
      checks++; if (vif.vstart_we !== 1'b1 || vif.new_vstart !== 32'd0) begin failures++; $display("FAIL empty_vstart c=%0d got=%0d/%0d exp=1/0", c, vif.vstart_we, vif.new_vstart); end
      step();
    end
  endtask

  task automatic test_back_to_back();
    issue(5'd0, 5'd0, 5'd0, 1'b0, 32'd4, 32'd0, 1'b1, 3'b010, 3'b000, 128'd0);
    vif.vill = 1'b0;
    vif.vl = 32'd2;
    vif.start_valid = 1'b1;
    #1;
    checks++; if (vif.start_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_in_ill got=%0d exp=0", vif.start_ready); end
    step();
    checks++; if (vif.start_ready !== 1'b1 || vif.busy !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%0d/%0d exp=1/0", vif.start_ready, vif.busy); end
    step();
    vif.start_valid = 1'b0;
    checks++; if (vif.elem_valid !== 1'b1 || vif.elem_idx !== 32'd0) begin failures++; $display("FAIL b2b_run got=%0d/%0d exp=1/0", vif.elem_valid, vif.elem_idx); end
    step();
    step();
    checks++; if (vif.done !== 1'b1) begin failures++; $display("FAIL b2b_done got=%0d exp=1", vif.done); end
    step();
  endtask

  task automatic test_flush();
    issue(5'd2, 5'd0, 5'd0, 1'b0, 32'd4, 32'd0, 1'b0, 3'b010, 3'b000, 128'd0);
    step();
    step();
    vif.flush = 1'b1;
    #1;
    checks++; if (vif.elem_idx !== 32'd2 || vif.vstart_we !== 1'b1 || vif.new_vstart !== 32'd3) begin failures++; $display("FAIL flush_wb got idx=%0d we=%0d nv=%0d exp=2/1/3", vif.elem_idx, vif.vstart_we, vif.new_vstart); end
    checks++; if (vif.start_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%0d exp=0", vif.start_ready); end
    step();
    vif.flush = 1'b0;
    checks++; if (vif.busy !== 1'b0 || vif.done !== 1'b0 || vif.elem_valid !== 1'b0) begin failures++; $display("FAIL flush_idle got b=%0d d=%0d v=%0d exp=0/0/0", vif.busy, vif.done, vif.elem_valid); end
    step();
    checks++; if (vif.done !== 1'b0) begin failures++; $display("FAIL flush_no_done got=%0d exp=0", vif.done); end
    issue(5'd2, 5'd0, 5'd0, 1'b0, 32'd4, 32'd3, 1'b0, 3'b010, 3'b000, 128'd0);
    checks++; if (vif.elem_idx !== 32'd3 || vif.elem_last !== 1'b1 || vif.elem_bit_offset !== 7'd96 || vif.new_vstart !== 32'd0) begin failures++; $display("FAIL restart got idx=%0d last=%0d off=%0d nv=%0d", vif.elem_idx, vif.elem_last, vif.elem_bit_offset, vif.new_vstart); end
    step();
    checks++; if (vif.done !== 1'b1) begin failures++; $display("FAIL restart_done got=%0d exp=1", vif.done); end
    step();
  endtask

  task automatic test_async_reset();
    issue(5'd2, 5'd0, 5'd0, 1'b1, 32'd4, 32'd0, 1'b0, 3'b010, 3'b000, 128'hF);
    step();
    checks++; if (vif.elem_valid !== 1'b1 || vif.elem_idx !== 32'd1) begin failures++; $display("FAIL areset_pre got=%0d/%0d exp=1/1", vif.elem_valid, vif.elem_idx); end
    rst_n = 1'b0;
    #1;
    checks++; if (vif.elem_valid !== 1'b0 || vif.vstart_we !== 1'b0 || vif.done !== 1'b0 || vif.illegal !== 1'b0) begin failures++; $display("FAIL areset_drop got v=%0d we=%0d d=%0d i=%0d", vif.elem_valid, vif.vstart_we, vif.done, vif.illegal); end
    checks++; if (vif.elem_idx !== 32'd0 || vif.new_vstart !== 32'd0 || vif.elem_active !== 1'b0 || vif.elem_vd !== 5'd0 || vif.busy !== 1'b0) begin failures++; $display("FAIL areset_zero got idx=%0d nv=%0d act=%0d vd=%0d busy=%0d", vif.elem_idx, vif.new_vstart, vif.elem_active, vif.elem_vd, vif.busy); end
    #2;
    rst_n = 1'b1;
    step();
    checks++; if (vif.start_ready !== 1'b1 || vif.elem_valid !== 1'b0) begin failures++; $display("FAIL areset_after got=%0d/%0d exp=1/0", vif.start_ready, vif.elem_valid); end
  endtask

  initial begin
    checks             = 0;
    failures           = 0;
    rst_n              = 1'b0;
    vif.start_valid    = 1'b0;
    vif.start_vd       = 5'd0;
    vif.start_vs1      = 5'd0;
    vif.start_vs2      = 5'd0;
    vif.start_masked   = 1'b0;
    vif.vl             = 32'd0;
    vif.vstart         = 32'd0;
    vif.vill           = 1'b0;
    vif.vsew           = 3'd0;
    vif.vlmul          = 3'd0;
    vif.mask_registers = '0;
    vif.flush          = 1'b0;
    vif.elem_ready     = 1'b1;
    test_reset();
    test_basic();
    test_clamp_group();
    test_mask();
    test_backpressure();
    test_illegal();
    test_empty();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
